// File: rtl/rx_slot_scheduler_pkg.sv
// Shared definitions for the RX slot scheduler: default sizes, FSM states, reset address map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rx_slot_scheduler_pkg;

  localparam int SLOT_COUNT_DEFAULT = 16;
  localparam int SLOT_WIDTH_DEFAULT = 4;
  localparam int ADDR_WIDTH_DEFAULT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_t;

  // Reset-time base address of a slot: slots are spread evenly over the address space.
  function automatic int unsigned default_slot_addr(int unsigned slot,
                                                    int unsigned addr_w,
                                                    int unsigned slot_w);
    return slot << (addr_w - slot_w);
  endfunction

endpackage

// File: rtl/rx_slot_scheduler_slot_free_fifo.sv
// Free-slot pool: synchronous FIFO with combinational head and occupancy count.
// Latency: pushed entry visible at head one edge after the push; count updates on that same edge.
// Backpressure: none upstream; pushes while full and pops while empty are ignored.
module slot_free_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr[PW-1:0]];
  assign count   = wr_ptr - rd_ptr;

  // Advance read and write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rx_slot_scheduler.sv
// Hands free packet-buffer slots to the RX DMA as {tag, addr} descriptors and recycles released slots.
// Latency: a release into an empty pool with idle output appears as a valid descriptor one edge later.
// Backpressure: AXIS valid/ready on descriptors (held stable while stalled); releases are never stalled.
module rx_slot_scheduler
  import rx_slot_scheduler_pkg::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEFAULT,
  parameter int SLOT_WIDTH = $clog2(SLOT_COUNT),
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SLOT_WIDTH-1:0] slot_addr_wr_no,
  input  logic [ADDR_WIDTH-1:0] slot_addr_wr_data,
  input  logic                  slot_addr_wr_valid,
  output logic [ADDR_WIDTH-1:0] m_axis_rx_desc_addr,
  output logic [SLOT_WIDTH-1:0] m_axis_rx_desc_tag,
  output logic                  m_axis_rx_desc_valid,
  input  logic                  m_axis_rx_desc_ready,
  input  logic [SLOT_WIDTH-1:0] slot_release_tag,
  input  logic                  slot_release_valid,
  output logic [SLOT_WIDTH:0]   free_slot_count,
  output logic [SLOT_COUNT-1:0] busy_slots,
  output logic                  err_double_release
);

  sched_state_t          state;
  logic [SLOT_WIDTH-1:0] init_idx;
  logic [ADDR_WIDTH-1:0] addr_table [SLOT_COUNT];
  logic [SLOT_COUNT-1:0] busy_next;

  logic                  fifo_push;
  logic [SLOT_WIDTH-1:0] fifo_push_tag;
  logic                  fifo_empty;
  logic [SLOT_WIDTH-1:0] fifo_head;
  logic                  rel_ok;
  logic                  handshake;
  logic                  load;

  // A release is only legal for a slot currently owned by the DMA/core.
  assign rel_ok    = slot_release_valid && busy_slots[slot_release_tag];
  assign handshake = m_axis_rx_desc_valid && m_axis_rx_desc_ready;
  assign load      = (state == ST_RUN) && go && !fifo_empty &&
                     (!m_axis_rx_desc_valid || m_axis_rx_desc_ready);

  // During init the pool is filled from the counter; afterwards only released slots enter it.
  // Releases cannot be legal during init (nothing is busy), so the two sources never collide.
  assign fifo_push     = (state == ST_INIT) || rel_ok;
  assign fifo_push_tag = (state == ST_INIT) ? init_idx : slot_release_tag;

  slot_free_fifo #(
    .DEPTH (SLOT_COUNT),
    .WIDTH (SLOT_WIDTH)
  ) u_free_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_tag),
    .pop       (load),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (free_slot_count)
  );

  // Control FSM: wait for go, seed the pool with every slot once, then run until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      init_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_INIT;
            init_idx <= '0;
          end
        end
        ST_INIT: begin
          init_idx <= init_idx + SLOT_WIDTH'(1);
          if (init_idx == SLOT_WIDTH'(SLOT_COUNT - 1)) state <= ST_RUN;
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Slot address table; the load reads the pre-write value when both hit the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOT_COUNT; i++) begin
        addr_table[i] <= ADDR_WIDTH'(default_slot_addr(i, ADDR_WIDTH, SLOT_WIDTH));
      end
    end else if (slot_addr_wr_valid) begin
      addr_table[slot_addr_wr_no] <= slot_addr_wr_data;
    end
  end

  // Descriptor output register: refill from the pool head, otherwise drop valid on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_rx_desc_valid <= 1'b0;
      m_axis_rx_desc_tag   <= '0;
      m_axis_rx_desc_addr  <= '0;
    end else if (load) begin
      m_axis_rx_desc_valid <= 1'b1;
      m_axis_rx_desc_tag   <= fifo_head;
      m_axis_rx_desc_addr  <= addr_table[fifo_head];
    end else if (handshake) begin
      m_axis_rx_desc_valid <= 1'b0;
    end
  end

  // Busy set: release is judged against the old set, then an accepted descriptor marks its slot.
  always_comb begin
    busy_next = busy_slots;
    if (rel_ok)    busy_next[slot_release_tag]   = 1'b0;
    if (handshake) busy_next[m_axis_rx_desc_tag] = 1'b1;
  end

  // Ownership tracking and one-cycle error pulse for releases of slots not owned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_slots         <= '0;
      err_double_release <= 1'b0;
    end else begin
      busy_slots         <= busy_next;
      err_double_release <= slot_release_valid && !busy_slots[slot_release_tag];
    end
  end

endmodule

// File: tb/tb_rx_slot_scheduler.sv
module tb_rx_slot_scheduler;
  localparam int N  = 16;
  localparam int SW = 4;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [SW-1:0] wr_no = '0;
  logic [AW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] d_addr;
  logic [SW-1:0] d_tag;
  logic          d_valid;
  logic          ready = 1'b0;
  logic [SW-1:0] rel_tag = '0;
  logic          rel_valid = 1'b0;
  logic [SW:0]   count;
  logic [N-1:0]  busy;
  logic          err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rx_slot_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .go                   (go),
    .slot_addr_wr_no      (wr_no),
    .slot_addr_wr_data    (wr_data),
    .slot_addr_wr_valid   (wr_valid),
    .m_axis_rx_desc_addr  (d_addr),
    .m_axis_rx_desc_tag   (d_tag),
    .m_axis_rx_desc_valid (d_valid),
    .m_axis_rx_desc_ready (ready),
    .slot_release_tag     (rel_tag),
    .slot_release_valid   (rel_valid),
    .free_slot_count      (count),
    .busy_slots           (busy),
    .err_double_release   (err)
  );

  // Reference model: pool as a queue of slot numbers, ownership as a bit per slot.
  int free_q[$];
  bit m_busy[N];
  int m_tbl[N];
  bit m_pv;
  int m_ptag;
  int m_paddr;
  bit m_err;
  bit m_running;
  int m_init_pos;

  function automatic logic [N-1:0] m_busy_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_tbl[i]  = i * 8;
    end
    m_pv = 0; m_ptag = 0; m_paddr = 0; m_err = 0;
    m_running = 0; m_init_pos = -1;
  endtask

  task automatic model_edge();
    bit rel_good, hs, ld;
    int t;
    rel_good = rel_valid && m_busy[rel_tag];
    hs       = m_pv && ready;
    ld       = m_running && go && (free_q.size() > 0) && (!m_pv || ready);
    m_err    = rel_valid && !m_busy[rel_tag];
    if (rel_good) m_busy[rel_tag] = 1'b0;
    if (hs)       m_busy[m_ptag]  = 1'b1;
    if (ld) begin
      t = free_q.pop_front();
      m_ptag = t; m_paddr = m_tbl[t]; m_pv = 1;
    end else if (hs) begin
      m_pv = 0;
    end
    if (rel_good) free_q.push_back(int'(rel_tag));
    if (m_init_pos >= 0) begin
      free_q.push_back(m_init_pos);
      if (m_init_pos == N - 1) begin
        m_init_pos = -1;
        m_running  = 1;
      end else begin
        m_init_pos++;
      end
    end else if (!m_running && go) begin
      m_init_pos = 0;
    end
    if (wr_valid) m_tbl[wr_no] = int'(wr_data);
  endtask

  // One clock: model follows the edge, caller resumes at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) step();
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", d_valid); end
    total++; if (d_tag !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", d_tag); end
    total++; if (d_addr !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0h want=0", d_addr); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (busy !== 16'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b0;
  endtask

  task automatic test_init_issue();
    int seen, waited;
    logic [AW-1:0] exp_addr;
    wr_no = 4'd5; wr_data = 7'h55; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    ready = 1'b1;
    seen = 0;
    repeat (1000) begin
      step();
      if (d_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL idle_no_issue got=%0d valid cycles want=0", seen); end
    go = 1'b1;
    waited = 0;
    while (d_valid !== 1'b1 && waited < 40) begin step(); waited++; end
    total++; if (waited != 18) begin bad++; $display("FAIL init_latency got=%0d edges want=18", waited); end
    for (int k = 0; k < N; k++) begin
      exp_addr = (k == 5) ? 7'h55 : 7'(k * 8);
      total++;
      if (d_valid !== 1'b1 || d_tag !== SW'(k) || d_addr !== exp_addr) begin
        bad++; $display("FAIL init_desc%0d got v=%b tag=%0d addr=%h want v=1 tag=%0d addr=%h", k, d_valid, d_tag, d_addr, k, exp_addr);
      end
      step();
    end
    total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL init_drain_valid got=%b want=0", d_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL init_count got=%0d want=0", count); end
    total++; if (busy !== 16'hFFFF) begin bad++; $display("FAIL init_busy got=%h want=ffff", busy); end
  endtask

  task automatic test_stall();
    ready = 1'b0;
    rel_tag = 4'd2; rel_valid = 1'b1;
    step();
    rel_tag = 4'd4;
    step();
    rel_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (d_valid !== 1'b1 || d_tag !== 4'd2 || d_addr !== 7'h10) begin
        bad++; $display("FAIL stall_hold%0d got v=%b tag=%0d addr=%h want v=1 tag=2 addr=10", c, d_valid, d_tag, d_addr);
      end
      step();
    end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL stall_count got=%0d want=1", count); end
    ready = 1'b1;
    step();
    total++;
    if (d_valid !== 1'b1 || d_tag !== 4'd4 || d_addr !== 7'h20) begin
      bad++; $display("FAIL stall_next got v=%b tag=%0d addr=%h want v=1 tag=4 addr=20", d_valid, d_tag, d_addr);
    end
    step();
    total++; if (busy !== 16'hFFFF || d_valid !== 1'b0) begin bad++; $display("FAIL stall_end got busy=%h v=%b want busy=ffff v=0", busy, d_valid); end
  endtask

  task automatic test_release_reissue();
    rel_tag = 4'd9; rel_valid = 1'b1;
    step();
    rel_valid = 1'b0;
    total++; if (busy[9] !== 1'b0 || count !== 5'd1 || d_valid !== 1'b0) begin
      bad++; $display("FAIL rel9_accept got busy9=%b count=%0d v=%b want 0,1,0", busy[9], count, d_valid);
    end
    step();
    total++;
    if (d_valid !== 1'b1 || d_tag !== 4'd9 || d_addr !== 7'h48 || count !== 5'd0) begin
      bad++; $display("FAIL rel9_issue got v=%b tag=%0d addr=%h count=%0d want v=1 tag=9 addr=48 count=0", d_valid, d_tag, d_addr, count);
    end
    total++; if (busy[9] !== 1'b0) begin bad++; $display("FAIL rel9_busy_pre got=%b want=0", busy[9]); end
    step();
    total++; if (busy[9] !== 1'b1 || d_valid !== 1'b0) begin bad++; $display("FAIL rel9_busy_post got busy9=%b v=%b want 1,0", busy[9], d_valid); end
  endtask

  task automatic test_double_release();
    go = 1'b0; ready = 1'b0;
    rel_tag = 4'd3; rel_valid = 1'b1;
    step();
    total++; if (err !== 1'b0 || count !== 5'd1) begin bad++; $display("FAIL dbl_first got err=%b count=%0d want 0,1", err, count); end
    step();
    rel_valid = 1'b0;
    total++; if (err !== 1'b1 || count !== 5'd1) begin bad++; $display("FAIL dbl_second got err=%b count=%0d want 1,1", err, count); end
    step();
    total++; if (err !== 1'b0 || count !== 5'd1) begin bad++; $display("FAIL dbl_pulse_end got err=%b count=%0d want 0,1", err, count); end
    go = 1'b1; ready = 1'b1;
    step();
    total++; if (d_valid !== 1'b1 || d_tag !== 4'd3) begin bad++; $display("FAIL dbl_reissue got v=%b tag=%0d want 1,3", d_valid, d_tag); end
    step();
    total++; if (busy !== 16'hFFFF || count !== 5'd0) begin bad++; $display("FAIL dbl_end got busy=%h count=%0d want ffff,0", busy, count); end
  endtask

  task automatic test_same_cycle();
    ready = 1'b0;
    rel_tag = 4'd7; rel_valid = 1'b1;
    step();
    rel_valid = 1'b0;
    step();
    total++; if (d_valid !== 1'b1 || d_tag !== 4'd7) begin bad++; $display("FAIL same_pending got v=%b tag=%0d want 1,7", d_valid, d_tag); end
    ready = 1'b1; rel_tag = 4'd7; rel_valid = 1'b1;
    step();
    rel_valid = 1'b0;
    total++;
    if (err !== 1'b1 || busy[7] !== 1'b1 || count !== 5'd0 || d_valid !== 1'b0) begin
      bad++; $display("FAIL same_cycle got err=%b busy7=%b count=%0d v=%b want 1,1,0,0", err, busy[7], count, d_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      go        = ($urandom_range(0, 9) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      rel_valid = ($urandom_range(0, 2) == 0);
      rel_tag   = SW'($urandom_range(0, N - 1));
      wr_valid  = ($urandom_range(0, 15) == 0);
      wr_no     = SW'($urandom_range(0, N - 1));
      wr_data   = AW'($urandom_range(0, 127));
      step();
      total++; if (d_valid !== m_pv) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, d_valid, m_pv); end
      if (m_pv) begin
        total++;
        if (d_tag !== SW'(m_ptag) || d_addr !== AW'(m_paddr)) begin
          bad++; $display("FAIL rnd_desc c=%0d got tag=%0d addr=%h want tag=%0d addr=%h", c, d_tag, d_addr, m_ptag, m_paddr);
        end
      end
      total++; if (count !== (SW+1)'(free_q.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, free_q.size()); end
      total++; if (busy !== m_busy_vec()) begin bad++; $display("FAIL rnd_busy c=%0d got=%h want=%h", c, busy, m_busy_vec()); end
      total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err, m_err); end
    end
    rel_valid = 1'b0; wr_valid = 1'b0; go = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int seen, waited, pick;
    ready = 1'b0;
    for (int c = 0; c < 40 && d_valid !== 1'b1; c++) begin
      pick = -1;
      for (int i = 0; i < N; i++) if (pick < 0 && m_busy[i]) pick = i;
      rel_tag = SW'(pick < 0 ? 0 : pick);
      rel_valid = (pick >= 0);
      step();
      rel_valid = 1'b0;
    end
    total++; if (d_valid !== 1'b1) begin bad++; $display("FAIL mid_pending got v=%b want=1", d_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (d_valid !== 1'b0 || busy !== 16'h0 || count !== 5'd0) begin
      bad++; $display("FAIL mid_async got v=%b busy=%h count=%0d want 0,0,0", d_valid, busy, count);
    end
    model_reset();
    go = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    ready = 1'b1;
    seen = 0;
    repeat (20) begin step(); if (d_valid !== 1'b0) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_idle_hold got=%0d valid cycles want=0", seen); end
    go = 1'b1;
    waited = 0;
    while (d_valid !== 1'b1 && waited < 40) begin step(); waited++; end
    total++; if (waited != 18) begin bad++; $display("FAIL mid_restart_latency got=%0d want=18", waited); end
    for (int k = 0; k < N; k++) begin
      total++;
      if (d_valid !== 1'b1 || d_tag !== SW'(k) || d_addr !== AW'(k * 8)) begin
        bad++; $display("FAIL mid_desc%0d got v=%b tag=%0d addr=%h want v=1 tag=%0d addr=%h", k, d_valid, d_tag, d_addr, k, k * 8);
      end
      step();
    end
    total++; if (busy !== 16'hFFFF) begin bad++; $display("FAIL mid_end_busy got=%h want=ffff", busy); end
  endtask

  initial begin
    test_reset();
    test_init_issue();
    test_stall();
    test_release_reissue();
    test_double_release();
    test_same_cycle();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
